// File: rtl/param_register_file.sv
// Multi-ported register file: two combinational read ports, two write ports
// with port-1 priority, per-register valid bits and an optional hardwired r0.
module param_register_file #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [AW-1:0]    AA,
    input  logic [AW-1:0]    BA,
    input  logic             WR0,
    input  logic [AW-1:0]    DA0,
    input  logic [WIDTH-1:0] DataIn0,
    input  logic             WR1,
    input  logic [AW-1:0]    DA1,
    input  logic [WIDTH-1:0] DataIn1,
    input  logic             Clear,
    output logic [WIDTH-1:0] DataA,
    output logic [WIDTH-1:0] DataB,
    output logic             ValidA,
    output logic             ValidB,
    output logic             Conflict
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             conflict_q;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             byp_en;

    // A write to a hardwired r0 is dropped, but it still counts toward Conflict.
    assign wr0_ok = WR0 && !((ZERO_R0 != 0) && (DA0 == '0));
    assign wr1_ok = WR1 && !((ZERO_R0 != 0) && (DA1 == '0));
    assign byp_en = (BYPASS != 0) && Reset && !Clear;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            valid      <= '0;
            conflict_q <= 1'b0;
        end else if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            valid      <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= WR0 && WR1 && (DA0 == DA1);
            if (wr0_ok) begin
                regs[DA0]  <= DataIn0;
                valid[DA0] <= 1'b1;
            end
            // Port 1 is assigned last so it wins a same-address collision.
            if (wr1_ok) begin
                regs[DA1]  <= DataIn1;
                valid[DA1] <= 1'b1;
            end
        end
    end

    always_comb begin
        DataA  = regs[AA];
        ValidA = valid[AA];
        if (byp_en && wr1_ok && (DA1 == AA)) begin
            DataA  = DataIn1;
            ValidA = 1'b1;
        end else if (byp_en && wr0_ok && (DA0 == AA)) begin
            DataA  = DataIn0;
            ValidA = 1'b1;
        end
        if ((ZERO_R0 != 0) && (AA == '0)) begin
            DataA  = '0;
            ValidA = 1'b1;
        end
    end

    always_comb begin
        DataB  = regs[BA];
        ValidB = valid[BA];
        if (byp_en && wr1_ok && (DA1 == BA)) begin
            DataB  = DataIn1;
            ValidB = 1'b1;
        end else if (byp_en && wr0_ok && (DA0 == BA)) begin
            DataB  = DataIn0;
            ValidB = 1'b1;
        end
        if ((ZERO_R0 != 0) && (BA == '0)) begin
            DataB  = '0;
            ValidB = 1'b1;
        end
    end

    assign Conflict = conflict_q;

endmodule

// File: tb/tb_param_register_file.sv
// Drives a default-configured and a wide/no-bypass/no-r0 register file with
// shared stimulus and checks both against an array-based reference model.
module tb_param_register_file;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr0   = 1'b0;
    logic        wr1   = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  da0   = '0;
    logic [4:0]  da1   = '0;
    logic [4:0]  aa    = '0;
    logic [4:0]  ba    = '0;
    logic [15:0] din0  = '0;
    logic [15:0] din1  = '0;

    logic [7:0]  s_data_a, s_data_b;
    logic        s_valid_a, s_valid_b, s_conflict;
    logic [15:0] w_data_a, w_data_b;
    logic        w_valid_a, w_valid_b, w_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    param_register_file #(.WIDTH(8), .DEPTH(8), .ZERO_R0(1), .BYPASS(1)) dut_small (
        .Clk(clk), .Reset(rst_n), .AA(aa[2:0]), .BA(ba[2:0]),
        .WR0(wr0), .DA0(da0[2:0]), .DataIn0(din0[7:0]),
        .WR1(wr1), .DA1(da1[2:0]), .DataIn1(din1[7:0]),
        .Clear(clear), .DataA(s_data_a), .DataB(s_data_b),
        .ValidA(s_valid_a), .ValidB(s_valid_b), .Conflict(s_conflict)
    );

    param_register_file #(.WIDTH(16), .DEPTH(32), .ZERO_R0(0), .BYPASS(0)) dut_wide (
        .Clk(clk), .Reset(rst_n), .AA(aa), .BA(ba),
        .WR0(wr0), .DA0(da0), .DataIn0(din0),
        .WR1(wr1), .DA1(da1), .DataIn1(din1),
        .Clear(clear), .DataA(w_data_a), .DataB(w_data_b),
        .ValidA(w_valid_a), .ValidB(w_valid_b), .Conflict(w_conflict)
    );

    always #5 clk = ~clk;

    // Reference state: instance 0 is the small/default file, instance 1 the wide one.
    bit [15:0] mreg [2][32];
    bit        mval [2][32];
    bit        mconf [2];

    function automatic int depth_of(input int i);
        return (i == 0) ? 8 : 32;
    endfunction

    function automatic logic [15:0] mask_of(input int i);
        return (i == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic bit writable(input int i, input int a);
        return !(i == 0 && a == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || clear) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[i][r] <= '0;
                    mval[i][r] <= 1'b0;
                end
                mconf[i] <= 1'b0;
            end else begin
                int a0;
                int a1;
                a0 = int'(da0) % depth_of(i);
                a1 = int'(da1) % depth_of(i);
                mconf[i] <= wr0 && wr1 && (a0 == a1);
                if (wr0 && writable(i, a0)) begin
                    mreg[i][a0] <= din0 & mask_of(i);
                    mval[i][a0] <= 1'b1;
                end
                if (wr1 && writable(i, a1)) begin
                    mreg[i][a1] <= din1 & mask_of(i);
                    mval[i][a1] <= 1'b1;
                end
            end
        end
    end

    function automatic void model_read(input int i, input logic [4:0] addr,
                                       output logic [15:0] d, output logic v);
        int  a;
        int  a0;
        int  a1;
        bit  byp;
        a   = int'(addr) % depth_of(i);
        a0  = int'(da0) % depth_of(i);
        a1  = int'(da1) % depth_of(i);
        byp = (i == 0) && rst_n && !clear;
        d   = mreg[i][a];
        v   = mval[i][a];
        if (byp && wr1 && a1 == a && writable(i, a)) begin
            d = din1 & mask_of(i);
            v = 1'b1;
        end else if (byp && wr0 && a0 == a && writable(i, a)) begin
            d = din0 & mask_of(i);
            v = 1'b1;
        end
        if (i == 0 && a == 0) begin
            d = '0;
            v = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [15:0] d0,
                                 input logic w1, input logic [4:0] a1, input logic [15:0] d1,
                                 input logic clr, input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        wr0 = w0; da0 = a0; din0 = d0;
        wr1 = w1; da1 = a1; din1 = d1;
        clear = clr; aa = ra; ba = rb;
    endtask

    // Every cycle, just before the rising edge, compare all outputs to the model.
    initial begin
        logic [15:0] ed;
        logic        ev;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #4;
            model_read(0, aa, ed, ev);
            checkOutput("small DataA", {8'h00, s_data_a}, ed);
            checkOutput("small ValidA", {15'd0, s_valid_a}, {15'd0, ev});
            model_read(0, ba, ed, ev);
            checkOutput("small DataB", {8'h00, s_data_b}, ed);
            checkOutput("small ValidB", {15'd0, s_valid_b}, {15'd0, ev});
            checkOutput("small Conflict", {15'd0, s_conflict}, {15'd0, mconf[0]});
            model_read(1, aa, ed, ev);
            checkOutput("wide DataA", w_data_a, ed);
            checkOutput("wide ValidA", {15'd0, w_valid_a}, {15'd0, ev});
            model_read(1, ba, ed, ev);
            checkOutput("wide DataB", w_data_b, ed);
            checkOutput("wide ValidB", {15'd0, w_valid_b}, {15'd0, ev});
            checkOutput("wide Conflict", {15'd0, w_conflict}, {15'd0, mconf[1]});
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        aa = 5'd3; ba = 5'd0;
        #1;
        checkOutput("reset small DataA", {8'h00, s_data_a}, 16'h0000);
        checkOutput("reset small ValidA", {15'd0, s_valid_a}, 16'h0000);
        checkOutput("reset small ValidB r0", {15'd0, s_valid_b}, 16'h0001);
        checkOutput("reset wide ValidB", {15'd0, w_valid_b}, 16'h0000);
        #1 rst_n = 1'b1;

        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, 5'(i), 16'hA010 + 16'(i), 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0);
        end
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'(i), 5'(8 - i));
            #3;
            checkOutput("sweep small DataA", {8'h00, s_data_a}, 16'h0010 + 16'(i));
            checkOutput("sweep small DataB", {8'h00, s_data_b}, 16'h0018 - 16'(i));
            checkOutput("sweep small ValidA", {15'd0, s_valid_a}, 16'h0001);
            checkOutput("sweep wide DataA", w_data_a, 16'hA010 + 16'(i));
        end

        // Same-address collision on both write ports
        applyStimulus(1'b1, 5'd3, 16'h00AA, 1'b1, 5'd3, 16'h0055, 1'b0, 5'd3, 5'd0);
        #3;
        checkOutput("collide bypass small DataA", {8'h00, s_data_a}, 16'h0055);
        checkOutput("collide no-bypass wide DataA", w_data_a, 16'hA013);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd3, 5'd0);
        #3;
        checkOutput("collide small DataA", {8'h00, s_data_a}, 16'h0055);
        checkOutput("collide small Conflict", {15'd0, s_conflict}, 16'h0001);
        checkOutput("collide wide DataA", w_data_a, 16'h0055);
        checkOutput("collide wide Conflict", {15'd0, w_conflict}, 16'h0001);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd3, 5'd0);
        #3;
        checkOutput("collide small Conflict drop", {15'd0, s_conflict}, 16'h0000);

        // Same-cycle read of a register being written
        applyStimulus(1'b1, 5'd5, 16'h003C, 1'b0, 5'd0, 16'h0, 1'b0, 5'd5, 5'd0);
        #3;
        checkOutput("bypass small DataA", {8'h00, s_data_a}, 16'h003C);
        checkOutput("no-bypass wide DataA old", w_data_a, 16'hA015);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd5, 5'd0);
        #3;
        checkOutput("no-bypass wide DataA new", w_data_a, 16'h003C);

        // Write to r0
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd0, 16'h00FF, 1'b0, 5'd0, 5'd0);
        #3;
        checkOutput("r0 during small DataA", {8'h00, s_data_a}, 16'h0000);
        checkOutput("r0 during small ValidA", {15'd0, s_valid_a}, 16'h0001);
        checkOutput("r0 during wide ValidA", {15'd0, w_valid_a}, 16'h0000);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0);
        #3;
        checkOutput("r0 after small DataA", {8'h00, s_data_a}, 16'h0000);
        checkOutput("r0 after small ValidA", {15'd0, s_valid_a}, 16'h0001);
        checkOutput("r0 after wide DataA", w_data_a, 16'h00FF);

        // Asynchronous reset between edges, then a write held across deassertion
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd2, 5'd6);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async rst small DataA", {8'h00, s_data_a}, 16'h0000);
        checkOutput("async rst small ValidA", {15'd0, s_valid_a}, 16'h0000);
        checkOutput("async rst small DataB", {8'h00, s_data_b}, 16'h0000);
        checkOutput("async rst small ValidB", {15'd0, s_valid_b}, 16'h0000);
        checkOutput("async rst wide DataA", w_data_a, 16'h0000);
        applyStimulus(1'b1, 5'd2, 16'h0077, 1'b0, 5'd0, 16'h0, 1'b0, 5'd2, 5'd6);
        #3;
        checkOutput("rst write ignored small DataA", {8'h00, s_data_a}, 16'h0000);
        checkOutput("rst write ignored small ValidA", {15'd0, s_valid_a}, 16'h0000);
        applyStimulus(1'b1, 5'd2, 16'h0077, 1'b0, 5'd0, 16'h0, 1'b0, 5'd2, 5'd6);
        #1 rst_n = 1'b1;
        #2;
        checkOutput("post rst bypass small DataA", {8'h00, s_data_a}, 16'h0077);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd2, 5'd6);
        #3;
        checkOutput("post rst small DataA", {8'h00, s_data_a}, 16'h0077);
        checkOutput("post rst small ValidB", {15'd0, s_valid_b}, 16'h0000);
        checkOutput("post rst wide DataA", w_data_a, 16'h0077);

        // Clear overrides a concurrent write and suppresses bypass
        applyStimulus(1'b1, 5'd4, 16'h0044, 1'b0, 5'd0, 16'h0, 1'b0, 5'd4, 5'd2);
        applyStimulus(1'b1, 5'd4, 16'h0099, 1'b0, 5'd0, 16'h0, 1'b1, 5'd4, 5'd2);
        #3;
        checkOutput("clear during small DataA", {8'h00, s_data_a}, 16'h0044);
        checkOutput("clear during small ValidA", {15'd0, s_valid_a}, 16'h0001);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd4, 5'd2);
        #3;
        checkOutput("clear after small DataA", {8'h00, s_data_a}, 16'h0000);
        checkOutput("clear after small ValidA", {15'd0, s_valid_a}, 16'h0000);
        checkOutput("clear after small ValidB", {15'd0, s_valid_b}, 16'h0000);
        checkOutput("clear after wide DataA", w_data_a, 16'h0000);

        // Top register of the wide file
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 5'd31, 16'hBEEF, 1'b0, 5'd0, 5'd31);
        #3;
        checkOutput("r31 during wide DataB", w_data_b, 16'h0000);
        checkOutput("r31 during small DataB", {8'h00, s_data_b}, 16'h00EF);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd31);
        #3;
        checkOutput("r31 wide DataB", w_data_b, 16'hBEEF);
        checkOutput("r31 wide ValidB", {15'd0, w_valid_b}, 16'h0001);
        applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd30);
        #3;
        checkOutput("r30 wide ValidB", {15'd0, w_valid_b}, 16'h0000);

        // Randomized traffic with collisions, clears and occasional resets
        for (int n = 0; n < 600; n++) begin
            logic [4:0] r0a;
            logic [4:0] r1a;
            r0a = 5'($urandom_range(0, 31));
            r1a = ($urandom_range(0, 1) == 0) ? r0a : 5'($urandom_range(0, 31));
            applyStimulus(($urandom_range(0, 3) != 0), r0a, 16'($urandom),
                          ($urandom_range(0, 2) != 0), r1a, 16'($urandom),
                          ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 1) == 0) ? r0a : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 1) == 0) ? r1a : 5'($urandom_range(0, 31)));
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
            end
        end

        @(negedge clk);
        rst_n = 1'b1;
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (power of 2, 2..256); AW = log2(DEPTH).
REQ-003 SHALL have parameter ZERO_R0, default 1, where 1 hardwires register 0 to all-zeros.
REQ-004 SHALL have parameter BYPASS, default 1, where 1 forwards same-cycle write data to the read ports.
REQ-005 Clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 AA  input  AW  read port A address.
REQ-008 BA  input  AW  read port B address.
REQ-009 WR0 / DA0 / DataIn0  input  1 / AW / WIDTH  write port 0 enable, address, data.
REQ-010 WR1 / DA1 / DataIn1  input  1 / AW / WIDTH  write port 1 enable, address, data.
REQ-011 Clear  input  1  synchronous clear of all registers and valid bits.
REQ-012 DataA / DataB  output  WIDTH  combinational read data for AA / BA.
REQ-013 ValidA / ValidB  output  1  register at AA / BA written since the last reset or clear.
REQ-014 Conflict  output  1  registered pulse: both ports wrote the same address last cycle.

Function
REQ-015 SHALL hold DEPTH registers of WIDTH bits, each with one valid bit.
REQ-016 On a Clk rising edge with WR0=1, SHALL write DataIn0 to reg[DA0] and set valid[DA0].
REQ-017 On a Clk rising edge with WR1=1, SHALL write DataIn1 to reg[DA1] and set valid[DA1].
REQ-018 If WR0=WR1=1 and DA0=DA1, port 1 SHALL win; the register SHALL take DataIn1.
REQ-019 In that collision case, Conflict SHALL be 1 for exactly the following cycle; otherwise Conflict SHALL be 0.
REQ-020 With ZERO_R0=1, writes to address 0 SHALL be ignored; reads of address 0 SHALL return 0 with Valid=1; Conflict SHALL still assert on an address-0 collision.
REQ-021 Reads SHALL be combinational with zero latency: DataA = reg[AA] and DataB = reg[BA] when no bypass applies.
REQ-022 With BYPASS=1, if a write enable is active to the read address in the current cycle, the read port SHALL return that write's data (port 1 priority) with Valid=1; this does not apply to address 0 when ZERO_R0=1.
REQ-023 With BYPASS=0, a read of a register written this cycle SHALL return the old value until after the edge.
REQ-024 Clear=1 at an edge SHALL zero all registers and valid bits and Conflict, overriding any write in the same cycle.
REQ-025 Bypass SHALL be suppressed while Clear=1: outputs show stored contents only.
REQ-026 Writes with WR0=WR1=0 SHALL leave all state unchanged; address inputs are don't-care.

Reset
REQ-027 Reset=0 SHALL immediately, without a clock, zero all registers, valid bits and Conflict.
REQ-028 While Reset=0, writes and Clear SHALL be ignored; reads SHALL return 0 with Valid=0, except address 0 when ZERO_R0=1, which returns Valid=1.
REQ-029 Reset asserted mid-write SHALL discard that write; the first write after deassertion SHALL take effect at the first rising edge with Reset=1.

Verification
REQ-030 Defaults: write 8'h11..8'h17 to regs 1..7 via WR0, then sweep AA and BA over 1..7 -> DataA and DataB = 8'h11..8'h17, ValidA and ValidB = 1.
REQ-031 WR0=1,DA0=3,DataIn0=8'hAA and WR1=1,DA1=3,DataIn1=8'h55 in one cycle -> reg3=8'h55; Conflict=1 for one cycle, then 0.
REQ-032 Defaults: WR0=1,DA0=5,DataIn0=8'h3C with AA=5 in the same cycle -> DataA=8'h3C before the edge; with BYPASS=0 -> old value, then 8'h3C after the edge.
REQ-033 WR1=1,DA1=0,DataIn1=8'hFF with ZERO_R0=1 -> DataA=0 at AA=0, ValidA=1 both during and after that cycle.
REQ-034 Load all regs, pulse Reset low between edges -> all reads 0 and Valid 0 without a clock; the same check with Clear=1 plus concurrent WR0 -> all 0, the write is dropped.
REQ-035 WIDTH=16, DEPTH=32: write reg31=16'hBEEF via port 1 -> DataB=16'hBEEF at BA=31; a read of never-written reg30 -> ValidB=0.
